// File: rtl/counter_defs_pkg.sv
// Shared definitions for the parametrised modulo counter family.
// Holds the count-direction type and the default parameter values.
package counter_defs_pkg;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } dir_e;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_MODULUS = 12;
  localparam int DEF_WRAP_W  = 8;

endpackage

// File: rtl/mod_next_calc.sv
// Combinational next-count, range-boundary detect and terminal count for a modulo-N counter.
// Define COUNTER_SATURATE_EN to hold at the boundary instead of wrapping.
module mod_next_calc
  import counter_defs_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic [WIDTH-1:0] count,
  input  dir_e             dir,
  input  logic             enable,
  input  logic             load,
  output logic [WIDTH-1:0] next_count,
  output logic             at_bound,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    next_count = count;
    at_bound   = 1'b0;
    case (dir)
      CNT_UP: begin
        at_bound   = (count == MAX_VAL);
        next_count = at_bound ? '0 : count + WIDTH'(1);
      end
      default: begin
        at_bound   = (count == '0);
        next_count = at_bound ? MAX_VAL : count - WIDTH'(1);
      end
    endcase
`ifdef COUNTER_SATURATE_EN
    if (at_bound) next_count = count;
`endif
  end

  // tc doubles as the "step leaves the range" event used for wrap/sat in the top.
  assign tc = enable & ~load & at_bound;

endmodule

// File: rtl/param_mod_counter.sv
// Parametrised modulo-N up/down counter with range-checked load, wrap pulse and wrap counter.
// Define COUNTER_SATURATE_EN to saturate at the range ends and expose the sticky sat output.
module param_mod_counter
  import counter_defs_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS,
  parameter int WRAP_W  = DEF_WRAP_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              enable,
  input  logic              up_down,
  output logic [WIDTH-1:0]  data_out,
  output logic              tc,
  output logic              wrap,
  output logic              load_err,
  output logic [WRAP_W-1:0] wrap_cnt
`ifdef COUNTER_SATURATE_EN
  ,
  output logic              sat
`endif
);

  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $fatal(1, "param_mod_counter: MODULUS must lie in 2..2**WIDTH");
    end
  endgenerate

  // One extra bit so MODULUS == 2**WIDTH is representable and every load is legal.
  localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic             load_ok;
  dir_e             dir;
  logic [WIDTH-1:0] next_count;
  logic             at_bound;

  assign load_ok = ({1'b0, data_in} < MOD_EXT);
  assign dir     = dir_e'(up_down);

  mod_next_calc #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_next (
    .count     (data_out),
    .dir       (dir),
    .enable    (enable),
    .load      (load),
    .next_count(next_count),
    .at_bound  (at_bound),
    .tc        (tc)
  );

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      data_out <= '0;
      load_err <= 1'b0;
    end else begin
      load_err <= 1'b0;
      if (load) begin
        if (load_ok) data_out <= data_in;
        else         load_err <= 1'b1;
      end else if (enable) begin
        data_out <= next_count;
      end
    end
  end

`ifdef COUNTER_SATURATE_EN
  assign wrap     = 1'b0;
  assign wrap_cnt = '0;

  always_ff @(posedge clock) begin
    if (reset)                sat <= 1'b0;
    else if (load && load_ok) sat <= 1'b0;
    else if (tc)              sat <= 1'b1;
  end
`else
  always_ff @(posedge clock) begin
    if (reset) begin
      wrap     <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      wrap <= tc;
      if (tc) wrap_cnt <= wrap_cnt + WRAP_W'(1);
    end
  end
`endif

endmodule
